prog_sequencer: RTL

- Front-end initiator for the cached-instruction calculator: accepts a program as (opcode, value) words over a valid/ready stream and buffers them in a small FIFO.
- Drives the calculator's mode/opCode/value inputs: a load phase (mode 0, one instruction per cycle) followed by an execute phase (mode 1) for a programmed number of cycles.
- Tracks the calculator's 32-entry cache capacity so instructions the calculator would refuse are never issued.

---
 rtl/prog_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/prog_sequencer.sv
// -----------------------------------------------------------------------------
// prog_sequencer
//
// Front end for the cached-instruction calculator. Program words
// (opcode, value) arrive over a valid/ready stream and are buffered in a
// small FIFO. Each buffered word is issued to the calculator for one cycle
// as a mode-0 load. After a start pulse the FIFO is drained, then mode 1
// (execute) is held for a programmed number of cycles. The block counts the
// words the calculator stores. Once the calculator's cache is full, further
// words are dropped instead of issued.
//
// Optional feature, controlled by the macro FILTER_INVALID_EN:
//   defined   - words with opcode 011 or 111 complete the handshake but are
//               dropped at the input and counted in discard_count.
//   undefined - those words are buffered and issued like any other word.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   in_valid/in_ready, in_op[2:0], in_value[3:0]   program word stream
//   start          begins drain + execute (sampled in IDLE only)
//   exec_cycles    number of mode-1 cycles, latched with start
//   clear_prog     zeroes both counters (IDLE only)
//   mode, opCode[2:0], value[3:0]                   calculator inputs
//   busy           high in DRAIN and EXEC
//   done           one-cycle pulse after EXEC
//   issued_count   storing instructions issued (0..CACHE_DEPTH)
//   discard_count  words dropped, saturating at 63
// -----------------------------------------------------------------------------
module prog_sequencer #(
   parameter int FIFO_DEPTH  = 8,
   parameter int CACHE_DEPTH = 32,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [2:0]       in_op,
   input  logic [3:0]       in_value,
   output logic             in_ready,
   input  logic             start,
   input  logic [CNT_W-1:0] exec_cycles,
   input  logic             clear_prog,
   output logic             mode,
   output logic [2:0]       opCode,
   output logic [3:0]       value,
   output logic             busy,
   output logic             done,
   output logic [5:0]       issued_count,
   output logic [5:0]       discard_count
);

   localparam int             PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [5:0]     CAP      = 6'(CACHE_DEPTH);
   localparam logic [2:0]     OP_IDLE  = 3'b011;

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_EXEC, S_DONE} state_t;

   state_t state, state_nxt;

   // FIFO storage: {opcode, value}
   logic [6:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   fifo_cnt;

   logic [CNT_W-1:0] exec_cnt, exec_cnt_nxt;

   // Issue register presented to the calculator
   logic             vld_p0;
   logic [2:0]       op_p0;
   logic [3:0]       val_p0;

   logic             fifo_empty, fifo_full;
   logic             accept, filtered, push, pop, clr;
   logic             cap_full, issue, discard_pop;
   logic [6:0]       head;
   logic [5:0]       issued_base, discard_base;
   logic [1:0]       discard_inc;

   // Opcodes 011 and 111 are decoded as invalid and never written to the cache.
   function automatic logic is_storing(input logic [2:0] op);
      return op[1:0] != 2'b11;
   endfunction

   function automatic logic [5:0] sat_add6(input logic [5:0] a, input logic [1:0] b);
      logic [6:0] s;
      s = {1'b0, a} + {5'b0, b};
      return s[6] ? 6'd63 : s[5:0];
   endfunction

   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == FULL_LVL);
   assign in_ready   = !fifo_full && (state == S_IDLE);
   assign accept     = in_valid && in_ready;

`ifdef FILTER_INVALID_EN
   assign filtered = accept && !is_storing(in_op);
`else
   assign filtered = 1'b0;
`endif

   assign push = accept && !filtered;
   assign pop  = ((state == S_IDLE) || (state == S_DRAIN)) && !fifo_empty;
   assign head = mem[rd_ptr];

   // A clear in IDLE takes effect before this cycle's count updates and
   // capacity check, so a concurrent issue starts counting from zero.
   assign clr          = clear_prog && (state == S_IDLE);
   assign issued_base  = clr ? 6'd0 : issued_count;
   assign discard_base = clr ? 6'd0 : discard_count;

   assign cap_full    = (issued_base == CAP);
   assign issue       = pop && !cap_full;
   assign discard_pop = pop && cap_full;
   assign discard_inc = 2'(discard_pop) + 2'(filtered);

   always_comb begin
      state_nxt    = state;
      exec_cnt_nxt = exec_cnt;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt    = S_DRAIN;
               exec_cnt_nxt = exec_cycles;
            end
         end
         S_DRAIN: begin
            // An empty FIFO here means the final pop is already on the outputs.
            if (fifo_empty) begin
               state_nxt = (exec_cnt == '0) ? S_DONE : S_EXEC;
            end
         end
         S_EXEC: begin
            exec_cnt_nxt = exec_cnt - CNT_W'(1);
            if (exec_cnt == CNT_W'(1)) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         exec_cnt      <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_cnt      <= '0;
         vld_p0        <= 1'b0;
         issued_count  <= '0;
         discard_count <= '0;
      end else begin
         state         <= state_nxt;
         exec_cnt      <= exec_cnt_nxt;
         vld_p0        <= issue;
         issued_count  <= issued_base + 6'(issue && is_storing(head[6:4]));
         discard_count <= sat_add6(discard_base, discard_inc);
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
            2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // ---- stage p0: popped head word captured for presentation ----
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_op, in_value};
      if (pop) begin
         op_p0  <= head[6:4];
         val_p0 <= head[3:0];
      end
   end

   // No issue can be pending in EXEC or DONE: both are entered only from a
   // DRAIN cycle with an empty FIFO, i.e. a cycle without a pop.
   assign mode   = (state == S_EXEC);
   assign opCode = vld_p0 ? op_p0 : OP_IDLE;
   assign value  = vld_p0 ? val_p0 : 4'd0;
   assign busy   = (state == S_DRAIN) || (state == S_EXEC);
   assign done   = (state == S_DONE);

endmodule
